// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions for the 3-bus datapath sequencers.
//   t_step_e  : T-step encoding (T0..T5, IDLE=7), visible on the step output
//   OPC_*     : register-register ALU opcodes
//   is_rr_op  : 1 when an opcode belongs to the register-register table
package cpu_ctrl_pkg;

    localparam int unsigned PKG_OPC_W = 5;

    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        T5   = 3'd5,
        IDLE = 3'd7
    } t_step_e;

    localparam logic [PKG_OPC_W-1:0] OPC_ADD = 5'h03;
    localparam logic [PKG_OPC_W-1:0] OPC_SUB = 5'h04;
    localparam logic [PKG_OPC_W-1:0] OPC_AND = 5'h09;
    localparam logic [PKG_OPC_W-1:0] OPC_OR  = 5'h0A;

    function automatic logic is_rr_op(input logic [PKG_OPC_W-1:0] opc);
        return (opc == OPC_ADD) || (opc == OPC_SUB) ||
               (opc == OPC_AND) || (opc == OPC_OR);
    endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// Register-field decoder: binary register index to one-hot select.
//   sel_i    : register index from an IR field
//   onehot_o : one-hot select, all zero when the index is out of range
//   oor_o    : index >= NUM_REGS
module reg_sel_decoder #(
    parameter int unsigned RSEL_W   = 4,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic [RSEL_W-1:0]   sel_i,
    output logic [NUM_REGS-1:0] onehot_o,
    output logic                oor_o
);

    always_comb begin
        onehot_o = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            onehot_o[i] = (sel_i == RSEL_W'(i));
        end
    end

    assign oor_o = (32'(sel_i) >= 32'(NUM_REGS));

endmodule

// File: rtl/alu_rr_sequencer.sv
// Control-step generator for register-register ALU instructions on the
// 3-bus datapath: fetch in T0-T2 (T1 stalls on mem_ready), execute in T3-T5.
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   run                   : start / continue the instruction stream
//   mem_ready             : memory read data valid this cycle
//   ir                    : current IR contents
//   *_out / *_in enables  : bus-drive and register-load strobes
//   inc_pc, read, alu_op  : ALU / memory controls
//   reg_out, reg_in       : one-hot GP register drive / load
//   step                  : current T-step, instr_done / illegal : 1-cycle pulses
module alu_rr_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned IR_W     = 32,
    parameter int unsigned OPC_W    = 5,
    parameter int unsigned RSEL_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                mem_ready,
    input  logic [IR_W-1:0]     ir,
    output logic                pc_out,
    output logic                zlow_out,
    output logic                mdr_out,
    output logic                mar_in,
    output logic                z_in,
    output logic                pc_in,
    output logic                mdr_in,
    output logic                ir_in,
    output logic                y_in,
    output logic                inc_pc,
    output logic                read,
    output logic [OPC_W-1:0]    alu_op,
    output logic [NUM_REGS-1:0] reg_out,
    output logic [NUM_REGS-1:0] reg_in,
    output logic [2:0]          step,
    output logic                instr_done,
    output logic                illegal
);

    localparam int unsigned RA_MSB = IR_W - OPC_W - 1;
    localparam int unsigned RB_MSB = RA_MSB - RSEL_W;
    localparam int unsigned RC_MSB = RB_MSB - RSEL_W;
    localparam int unsigned FREE_W = RC_MSB - RSEL_W + 1;

    t_step_e             state_q;
    logic                first_q;
    logic [OPC_W-1:0]    opc_q;
    logic [RSEL_W-1:0]   ra_q;
    logic [RSEL_W-1:0]   rc_q;

    logic [OPC_W-1:0]    opc_ir;
    logic [RSEL_W-1:0]   ra_ir, rb_ir, rc_ir;
    logic [RSEL_W-1:0]   out_sel, in_sel;
    logic [NUM_REGS-1:0] out_hot, in_hot;
    logic                out_oor, in_oor, rc_oor, bad_c;
    logic                unused_ir;

    assign opc_ir    = ir[IR_W-1 -: OPC_W];
    assign ra_ir     = ir[RA_MSB -: RSEL_W];
    assign rb_ir     = ir[RB_MSB -: RSEL_W];
    assign rc_ir     = ir[RC_MSB -: RSEL_W];
    assign unused_ir = ^ir[FREE_W-1:0];

    // In T3 the decoders look straight at the freshly loaded IR; later steps use latched fields.
    assign out_sel = (state_q == T3) ? rb_ir : rc_q;
    assign in_sel  = (state_q == T3) ? ra_ir : ra_q;
    assign rc_oor  = (32'(rc_ir) >= 32'(NUM_REGS));

    // Only meaningful in T3: unknown opcode or any register index out of range.
    assign bad_c = !is_rr_op(PKG_OPC_W'(opc_ir)) || in_oor || out_oor || rc_oor;

    reg_sel_decoder #(.RSEL_W(RSEL_W), .NUM_REGS(NUM_REGS)) u_out_dec (
        .sel_i    (out_sel),
        .onehot_o (out_hot),
        .oor_o    (out_oor)
    );

    reg_sel_decoder #(.RSEL_W(RSEL_W), .NUM_REGS(NUM_REGS)) u_in_dec (
        .sel_i    (in_sel),
        .onehot_o (in_hot),
        .oor_o    (in_oor)
    );

    // Step sequencing and field latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            first_q <= 1'b0;
            opc_q   <= '0;
            ra_q    <= '0;
            rc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (run) state_q <= T0;
                T0: begin
                    state_q <= T1;
                    first_q <= 1'b1;
                end
                T1: begin
                    first_q <= 1'b0;
                    if (mem_ready) state_q <= T2;
                end
                T2: state_q <= T3;
                T3: begin
                    opc_q <= opc_ir;
                    ra_q  <= ra_ir;
                    rc_q  <= rc_ir;
                    if (bad_c) state_q <= run ? T0 : IDLE;
                    else       state_q <= T4;
                end
                T4: state_q <= T5;
                T5: state_q <= run ? T0 : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Moore output decode from the step register.
    always_comb begin
        pc_out     = 1'b0;
        zlow_out   = 1'b0;
        mdr_out    = 1'b0;
        mar_in     = 1'b0;
        z_in       = 1'b0;
        pc_in      = 1'b0;
        mdr_in     = 1'b0;
        ir_in      = 1'b0;
        y_in       = 1'b0;
        inc_pc     = 1'b0;
        read       = 1'b0;
        alu_op     = '0;
        reg_out    = '0;
        reg_in     = '0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            T0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
            end
            T1: begin
                zlow_out = 1'b1;
                pc_in    = first_q;
                read     = 1'b1;
                mdr_in   = 1'b1;
            end
            T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            T3: begin
                if (bad_c) begin
                    illegal = 1'b1;
                end else begin
                    reg_out = out_hot;
                    y_in    = 1'b1;
                end
            end
            T4: begin
                reg_out = out_hot;
                alu_op  = opc_q;
                z_in    = 1'b1;
            end
            T5: begin
                zlow_out   = 1'b1;
                reg_in     = in_hot;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign step = 3'(state_q);

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Bench for alu_rr_sequencer: a 16-register and an 8-register instance, each
// driven independently and compared cycle by cycle against a step-table model.
module tb_alu_rr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_a [2];
    logic        mr_a  [2];
    logic [31:0] ir_a  [2];

    // {pc_out,zlow_out,mdr_out,mar_in,z_in,pc_in,mdr_in,ir_in,y_in,inc_pc,read,alu_op,step,instr_done,illegal}
    wire [20:0] ctrl_w0, ctrl_w1;
    wire [15:0] ro0, ri0;
    wire [7:0]  ro1, ri1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_rr_sequencer #(.NUM_REGS(16)) dut16 (
        .clk(clk), .reset(reset), .run(run_a[0]), .mem_ready(mr_a[0]), .ir(ir_a[0]),
        .pc_out(ctrl_w0[20]), .zlow_out(ctrl_w0[19]), .mdr_out(ctrl_w0[18]),
        .mar_in(ctrl_w0[17]), .z_in(ctrl_w0[16]), .pc_in(ctrl_w0[15]),
        .mdr_in(ctrl_w0[14]), .ir_in(ctrl_w0[13]), .y_in(ctrl_w0[12]),
        .inc_pc(ctrl_w0[11]), .read(ctrl_w0[10]), .alu_op(ctrl_w0[9:5]),
        .reg_out(ro0), .reg_in(ri0), .step(ctrl_w0[4:2]),
        .instr_done(ctrl_w0[1]), .illegal(ctrl_w0[0])
    );

    alu_rr_sequencer #(.NUM_REGS(8)) dut8 (
        .clk(clk), .reset(reset), .run(run_a[1]), .mem_ready(mr_a[1]), .ir(ir_a[1]),
        .pc_out(ctrl_w1[20]), .zlow_out(ctrl_w1[19]), .mdr_out(ctrl_w1[18]),
        .mar_in(ctrl_w1[17]), .z_in(ctrl_w1[16]), .pc_in(ctrl_w1[15]),
        .mdr_in(ctrl_w1[14]), .ir_in(ctrl_w1[13]), .y_in(ctrl_w1[12]),
        .inc_pc(ctrl_w1[11]), .read(ctrl_w1[10]), .alu_op(ctrl_w1[9:5]),
        .reg_out(ro1), .reg_in(ri1), .step(ctrl_w1[4:2]),
        .instr_done(ctrl_w1[1]), .illegal(ctrl_w1[0])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] irv, input int nregs);
        int opc, ra, rb, rc;
        opc = int'(irv >> 27);
        ra  = int'((irv >> 23) & 32'hF);
        rb  = int'((irv >> 19) & 32'hF);
        rc  = int'((irv >> 15) & 32'hF);
        return (opc == 3 || opc == 4 || opc == 9 || opc == 10) &&
               ra < nregs && rb < nregs && rc < nregs;
    endfunction

    // Expected control word for one step, straight from the step table.
    function automatic logic [20:0] exp_ctrl(input int st, input bit first, input bit bad,
                                             input logic [4:0] opc);
        bit pc_out, zlow_out, mdr_out, mar_in, z_in, pc_in, mdr_in, ir_in, y_in, inc_pc, read;
        bit done, ill;
        logic [4:0] alu;
        {pc_out, zlow_out, mdr_out, mar_in, z_in, pc_in, mdr_in, ir_in, y_in, inc_pc, read} = '0;
        done = 0; ill = 0; alu = '0;
        case (st)
            0: begin pc_out = 1; mar_in = 1; inc_pc = 1; z_in = 1; end
            1: begin zlow_out = 1; pc_in = first; read = 1; mdr_in = 1; end
            2: begin mdr_out = 1; ir_in = 1; end
            3: if (bad) ill = 1; else y_in = 1;
            4: begin alu = opc; z_in = 1; end
            5: begin zlow_out = 1; done = 1; end
            default: ;
        endcase
        return {pc_out, zlow_out, mdr_out, mar_in, z_in, pc_in, mdr_in, ir_in, y_in, inc_pc, read,
                alu, 3'(st), done, ill};
    endfunction

    // One clock: drive inputs, check outputs at the falling edge, advance to just past the next rising edge.
    task automatic cyc(input int d, input bit r, input bit mr, input int st, input bit first,
                       input logic [31:0] irv);
        int nregs, ra, rb, rc;
        bit bad;
        logic [4:0]  opc;
        logic [15:0] ero, eri, gro, gri;
        logic [20:0] gc;
        run_a[d] = r;
        mr_a[d]  = mr;
        ir_a[d]  = irv;
        nregs = (d == 0) ? 16 : 8;
        opc = 5'(irv >> 27);
        ra  = int'((irv >> 23) & 32'hF);
        rb  = int'((irv >> 19) & 32'hF);
        rc  = int'((irv >> 15) & 32'hF);
        bad = !legal(irv, nregs);
        @(negedge clk);
        ero = '0;
        eri = '0;
        if (st == 3 && !bad) ero = 16'(1) << rb;
        if (st == 4)         ero = 16'(1) << rc;
        if (st == 5)         eri = 16'(1) << ra;
        gc  = (d == 0) ? ctrl_w0 : ctrl_w1;
        gro = (d == 0) ? ro0 : {8'h00, ro1};
        gri = (d == 0) ? ri0 : {8'h00, ri1};
        check($sformatf("d%0d step%0d ctrl", d, st), 32'(gc),  32'(exp_ctrl(st, first, bad, opc)));
        check($sformatf("d%0d step%0d reg_out", d, st), 32'(gro), 32'(ero));
        check($sformatf("d%0d step%0d reg_in", d, st), 32'(gri), 32'(eri));
        @(posedge clk);
        #1;
    endtask

    // Full instruction; run is random wherever it must be ignored.
    task automatic do_instr(input int d, input logic [31:0] irv, input int stalls,
                            input bit run_end, input bit from_idle);
        bit bad;
        bad = !legal(irv, (d == 0) ? 16 : 8);
        if (from_idle) cyc(d, 1'b1, 1'($urandom_range(0, 1)), 7, 1'b0, irv);
        cyc(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1'b0, irv);
        for (int k = 0; k <= stalls; k++)
            cyc(d, 1'($urandom_range(0, 1)), (k == stalls), 1, (k == 0), irv);
        cyc(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2, 1'b0, irv);
        if (bad) begin
            cyc(d, run_end, 1'($urandom_range(0, 1)), 3, 1'b0, irv);
        end else begin
            cyc(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3, 1'b0, irv);
            cyc(d, run_end, 1'($urandom_range(0, 1)), 4, 1'b0, irv);
            cyc(d, run_end, 1'($urandom_range(0, 1)), 5, 1'b0, irv);
        end
    endtask

    function automatic logic [31:0] rand_ir();
        logic [4:0] opc;
        case ($urandom_range(0, 4))
            0: opc = 5'h03;
            1: opc = 5'h04;
            2: opc = 5'h09;
            3: opc = 5'h0A;
            default: opc = 5'($urandom_range(0, 31));
        endcase
        return {opc, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 15'($urandom)};
    endfunction

    logic [31:0] ir_and;
    logic [31:0] ir_bad_opc;
    logic [31:0] ir_bad_rc;

    initial begin
        ir_and     = 32'h4A92_0000;
        ir_bad_opc = 32'hF800_0000 | (32'd1 << 23) | (32'd2 << 19) | (32'd3 << 15);
        ir_bad_rc  = (32'd3 << 27) | (32'd1 << 23) | (32'd2 << 19) | (32'd12 << 15);
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            run_a[d] = 1'b0;
            mr_a[d]  = 1'b0;
            ir_a[d]  = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state on both instances.
        cyc(0, 1'b0, 1'b0, 7, 1'b0, '0);
        cyc(1, 1'b0, 1'b0, 7, 1'b0, '0);

        // AND R5 = R2 & R4, no stall, then with 3 stall cycles.
        do_instr(0, ir_and, 0, 1'b0, 1'b1);
        do_instr(0, ir_and, 3, 1'b0, 1'b1);

        // Illegal opcode with run held: straight back to T0, then a legal one.
        do_instr(0, ir_bad_opc, 0, 1'b1, 1'b1);
        do_instr(0, ir_and, 0, 1'b0, 1'b0);

        // Rc out of range on the 8-register instance.
        do_instr(1, ir_bad_rc, 1, 1'b0, 1'b1);
        cyc(1, 1'b0, 1'b0, 7, 1'b0, '0);

        // Reset during T4, then restart.
        cyc(0, 1'b1, 1'b0, 7, 1'b0, ir_and);
        cyc(0, 1'b1, 1'b0, 0, 1'b0, ir_and);
        cyc(0, 1'b1, 1'b1, 1, 1'b1, ir_and);
        cyc(0, 1'b1, 1'b0, 2, 1'b0, ir_and);
        cyc(0, 1'b1, 1'b0, 3, 1'b0, ir_and);
        reset = 1'b1;
        cyc(0, 1'b1, 1'b0, 4, 1'b0, ir_and);
        reset = 1'b0;
        cyc(0, 1'b1, 1'b0, 7, 1'b0, ir_and);
        do_instr(0, ir_and, 0, 1'b0, 1'b0);

        // Three back-to-back instructions, run dropped in T4 of the last.
        do_instr(0, ir_and, 0, 1'b1, 1'b1);
        do_instr(0, 32'h1A92_0000, 0, 1'b1, 1'b0);
        do_instr(0, 32'h2112_8000, 0, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b0, 7, 1'b0, '0);

        // Randomized streams on each instance, each ending idle.
        for (int d = 0; d < 2; d++) begin
            bit idle;
            idle = 1'b1;
            for (int i = 0; i < 25; i++) begin
                logic [31:0] irv;
                bit re;
                irv = rand_ir();
                re  = (i == 24) ? 1'b0 : 1'($urandom_range(0, 1));
                if (idle) repeat ($urandom_range(0, 2)) cyc(d, 1'b0, 1'($urandom_range(0, 1)), 7, 1'b0, irv);
                do_instr(d, irv, $urandom_range(0, 3), re, idle);
                idle = !re;
            end
            cyc(d, 1'b0, 1'b0, 7, 1'b0, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
